// File: rtl/mips_cpu_pkg.sv
// rtl/mips_cpu_pkg.sv - shared types and constants for the CPU data bridge
package mips_cpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } bridge_state_t;

    localparam logic [31:0] ERROR_DATA_DEFAULT = 32'hDEADBEEF;

endpackage

// File: rtl/mips_cpu_data_bridge_if.sv
// rtl/mips_cpu_data_bridge_if.sv - CPU data port and Avalon-style bus interfaces
interface mips_cpu_data_if;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_address;
    logic [3:0]  data_byteenable;
    logic [31:0] data_writedata;
    logic [31:0] data_readdata;

    modport master (
        output data_read, data_write, data_address, data_byteenable, data_writedata,
        input  data_readdata
    );

    modport slave (
        input  data_read, data_write, data_address, data_byteenable, data_writedata,
        output data_readdata
    );
endinterface

interface mips_cpu_avm_if;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    modport master (
        output avm_address, avm_read, avm_write, avm_byteenable, avm_writedata,
        input  avm_readdata, avm_waitrequest
    );

    modport slave (
        input  avm_address, avm_read, avm_write, avm_byteenable, avm_writedata,
        output avm_readdata, avm_waitrequest
    );
endinterface

// File: rtl/mips_cpu_bridge_timer.sv
// rtl/mips_cpu_bridge_timer.sv - saturating bus-wait timer with terminal count
module mips_cpu_bridge_timer #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic en,
    output logic tc
);

    localparam int              W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [W-1:0]    LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Holds at LAST so a late waitrequest drop cannot wrap the count
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (en && (count_q != LAST)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == LAST);

endmodule

// File: rtl/mips_cpu_data_bridge.sv
// rtl/mips_cpu_data_bridge.sv - stalls the CPU while one data access runs on a wait-state bus
module mips_cpu_data_bridge
    import mips_cpu_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 256,
    parameter logic [31:0] ERROR_DATA     = ERROR_DATA_DEFAULT
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            sys_clk_enable,
    output logic            cpu_clk_enable,
    mips_cpu_data_if.slave  cpu,
    mips_cpu_avm_if.master  avm,
    output logic            bus_error
);

    bridge_state_t state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [3:0]    be_q, be_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          rd_q, rd_d;
    logic          wr_q, wr_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;
    logic          req;
    logic          timer_tc;

    assign req = cpu.data_read | cpu.data_write;

    mips_cpu_bridge_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (state_q == IDLE),
        .en      (state_q == BUS),
        .tc      (timer_tc)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = BUS;
                    addr_d  = cpu.data_address;
                    be_d    = cpu.data_byteenable;
                    wdata_d = cpu.data_writedata;
                    // A simultaneous read+write is issued as a write only
                    wr_d    = cpu.data_write;
                    rd_d    = cpu.data_read & ~cpu.data_write;
                end
            end
            BUS: begin
                if (!avm.avm_waitrequest) begin
                    if (rd_q) begin
                        rdata_d = avm.avm_readdata;
                    end
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = DONE;
                end else if (timer_tc) begin
                    if (rd_q) begin
                        rdata_d = ERROR_DATA;
                    end
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (sys_clk_enable) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Combinational from the CPU strobes so an idle CPU is never stalled
    assign cpu_clk_enable = sys_clk_enable & reset_n &
                            (((state_q == IDLE) & ~req) | (state_q == DONE));

    assign avm.avm_address    = addr_q;
    assign avm.avm_byteenable = be_q;
    assign avm.avm_writedata  = wdata_q;
    assign avm.avm_read       = rd_q;
    assign avm.avm_write      = wr_q;
    assign cpu.data_readdata  = rdata_q;
    assign bus_error          = err_q;

endmodule
